table_scan_sel: RTL and testbench

Parametrised, registered successor to the fixed 5x4 32-bit table selector. It picks one WIDTH-bit entry out of a ROWS x COLS table. In manual mode it uses a one-hot-priority row and a binary column. In scan mode it walks every entry in row-major order over a valid/ready stream. It sits between processor-internal state tables (register file, CSR, pipeline snapshots) and the debug display/UART dump path.

---
 rtl/table_scan_sel.sv | 165 ++++++++++++++++
 tb/tb_table_scan_sel.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/table_scan_sel.sv
// Registered ROWS x COLS table selector. Manual mode picks one entry by a priority row
// and a binary column. Scan mode streams every entry in row-major order over valid/ready.
module table_scan_sel #(
  parameter int               WIDTH   = 32,
  parameter int               ROWS    = 5,
  parameter int               COLS    = 4,
  parameter logic [WIDTH-1:0] DEFAULT = WIDTH'(32'hDEADBEEF),
  localparam int              RW      = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int              CW      = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ROWS*COLS*WIDTH-1:0]  in_flat,
  input  logic [ROWS-1:0]             row,
  input  logic [CW-1:0]               col,
  input  logic                        mode,
  input  logic                        start,
  input  logic                        continuous,
  input  logic                        abort,
  output logic [WIDTH-1:0]            out_data,
  output logic [RW-1:0]               out_row,
  output logic [CW-1:0]               out_col,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        hit,
  output logic                        busy
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [RW-1:0]    row_q,   row_d;
  logic [CW-1:0]    col_q,   col_d;
  logic             valid_q, valid_d;
  logic             last_q,  last_d;
  logic             hit_q,   hit_d;

  int   man_row;
  logic man_found;
  logic man_hit;
  int   nxt_row;
  int   nxt_col;
  logic cur_final;

  // NOTE: every variable written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    row_d     = row_q;
    col_d     = col_q;
    valid_d   = valid_q;
    last_d    = last_q;
    hit_d     = hit_q;
    man_row   = 0;
    man_found = 1'b0;

    // Descending walk so the lowest set row bit is the one left standing.
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (row[i]) begin
        man_found = 1'b1;
        man_row   = i;
      end
    end
    man_hit = man_found && (int'(col) < COLS);

    // Row-major successor of the index currently on the output.
    cur_final = (int'(row_q) == ROWS - 1) && (int'(col_q) == COLS - 1);
    if (int'(col_q) == COLS - 1) begin
      nxt_col = 0;
      nxt_row = (int'(row_q) == ROWS - 1) ? 0 : int'(row_q) + 1;
    end else begin
      nxt_col = int'(col_q) + 1;
      nxt_row = int'(row_q);
    end

    if (abort && state_q == SCAN) begin
      state_d = IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
      hit_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!mode) begin
            valid_d = 1'b1;
            last_d  = 1'b0;
            col_d   = col;
            hit_d   = man_hit;
            if (man_hit) begin
              data_d = in_flat[(man_row * COLS + int'(col)) * WIDTH +: WIDTH];
              row_d  = RW'(man_row);
            end else begin
              data_d = DEFAULT;
              row_d  = '0;
            end
          end else if (start) begin
            state_d = SCAN;
            data_d  = in_flat[0 +: WIDTH];
            row_d   = '0;
            col_d   = '0;
            valid_d = 1'b1;
            last_d  = (ROWS * COLS == 1);
            hit_d   = 1'b0;
          end else begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            hit_d   = 1'b0;
          end
        end

        SCAN: begin
          if (valid_q && out_ready) begin
            if (cur_final && !continuous) begin
              state_d = IDLE;
              valid_d = 1'b0;
              last_d  = 1'b0;
            end else begin
              // On the final beat nxt_* already wraps to (0,0), which is the restart.
              data_d = in_flat[(nxt_row * COLS + nxt_col) * WIDTH +: WIDTH];
              row_d  = RW'(nxt_row);
              col_d  = CW'(nxt_col);
              last_d = (nxt_row == ROWS - 1) && (nxt_col == COLS - 1);
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= DEFAULT;
      row_q   <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      row_q   <= row_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      hit_q   <= hit_d;
    end
  end

  assign out_data  = data_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign hit       = hit_q;
  assign busy      = (state_q == SCAN);

endmodule

// File: tb/tb_table_scan_sel.sv
// Self-checking bench for table_scan_sel: a cycle model built from the behavioural rules,
// compared every cycle, plus literal expectations for the 5x4 default table.
module tb_table_scan_sel;

  localparam int               WIDTH = 32;
  localparam int               ROWS  = 5;
  localparam int               COLS  = 4;
  localparam int               N     = ROWS * COLS;
  localparam logic [WIDTH-1:0] DEF   = 32'hDEADBEEF;

  logic                       clk;
  logic                       rst;
  logic [ROWS*COLS*WIDTH-1:0] in_flat;
  logic [ROWS-1:0]            row;
  logic [1:0]                 col;
  logic                       mode, start, continuous, abort, out_ready;
  logic [WIDTH-1:0]           out_data;
  logic [2:0]                 out_row;
  logic [1:0]                 out_col;
  logic                       out_valid, out_last, hit, busy;

  logic [WIDTH-1:0] tbl [ROWS][COLS];

  int checks = 0;
  int errors = 0;

  table_scan_sel #(.WIDTH(WIDTH), .ROWS(ROWS), .COLS(COLS), .DEFAULT(DEF)) dut (
    .clk(clk), .rst(rst), .in_flat(in_flat), .row(row), .col(col), .mode(mode),
    .start(start), .continuous(continuous), .abort(abort), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .hit(hit), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    in_flat = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        in_flat[(r * COLS + c) * WIDTH +: WIDTH] = tbl[r][c];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic init_tbl();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        tbl[r][c] = 32'h10000000 + 32'(16 * r + c);
  endtask

  task automatic scramble_tbl();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        tbl[r][c] = tbl[r][c] ^ 32'hFFFF0000;
  endtask

  function automatic logic [31:0] exp_seq(input int i);
    return 32'h10000000 + 32'(16 * (i / COLS) + (i % COLS));
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Behavioural model: scan position is a single linear beat number k in 0..N-1.
  logic [WIDTH-1:0] e_data;
  int               e_row, e_col, m_k;
  logic             e_valid, e_last, e_hit, e_busy;
  logic             model_live = 1'b0;

  task automatic load_beat();
    e_row   = m_k / COLS;
    e_col   = m_k % COLS;
    e_data  = tbl[e_row][e_col];
    e_valid = 1'b1;
    e_last  = (m_k == N - 1);
  endtask

  always @(posedge clk) begin
    int r;
    model_live = 1'b1;
    if (rst) begin
      e_data = DEF; e_row = 0; e_col = 0; e_valid = 0; e_last = 0; e_hit = 0; e_busy = 0; m_k = 0;
    end else if (e_busy && abort) begin
      e_busy = 0; e_valid = 0; e_last = 0;
    end else if (!e_busy) begin
      if (!mode) begin
        r = -1;
        for (int i = 0; i < ROWS; i++)
          if (row[i] && r < 0) r = i;
        e_col = int'(col); e_valid = 1; e_last = 0;
        if (r >= 0 && int'(col) < COLS) begin
          e_data = tbl[r][col]; e_row = r; e_hit = 1;
        end else begin
          e_data = DEF; e_row = 0; e_hit = 0;
        end
      end else if (start) begin
        e_busy = 1; m_k = 0; e_hit = 0;
        load_beat();
      end else begin
        e_valid = 0; e_hit = 0; e_last = 0;
      end
    end else if (out_ready) begin
      if (m_k == N - 1) begin
        if (continuous) begin
          m_k = 0;
          load_beat();
        end else begin
          e_busy = 0; e_valid = 0; e_last = 0;
        end
      end else begin
        m_k++;
        load_beat();
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("m_data",  64'(out_data),  64'(e_data));
      check("m_row",   64'(out_row),   64'(e_row));
      check("m_col",   64'(out_col),   64'(e_col));
      check("m_valid", 64'(out_valid), 64'(e_valid));
      check("m_last",  64'(out_last),  64'(e_last));
      check("m_hit",   64'(hit),       64'(e_hit));
      check("m_busy",  64'(busy),      64'(e_busy));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int pat [6] = '{1, 0, 0, 1, 0, 1};
    logic [WIDTH-1:0] held;
    logic held_valid;
    int got, cyc;

    init_tbl();
    rst = 1; mode = 0; row = 5'b00101; col = 2'd1; start = 1; continuous = 1; abort = 1; out_ready = 1;
    tick(); tick();
    check("rst_data",  64'(out_data),  64'hDEADBEEF);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy",  64'(busy),      64'd0);
    check("rst_hit",   64'(hit),       64'd0);
    check("rst_last",  64'(out_last),  64'd0);

    // Manual selection
    rst = 0; start = 0; continuous = 0; abort = 0;
    row = 5'b10110; col = 2'd2;
    tick();
    check("man_data", 64'(out_data), 64'h10000012);
    check("man_row",  64'(out_row),  64'd1);
    check("man_hit",  64'(hit),      64'd1);
    row = 5'b00000;
    tick();
    check("man_miss_data", 64'(out_data), 64'hDEADBEEF);
    check("man_miss_hit",  64'(hit),      64'd0);
    row = 5'b10000; col = 2'd3;
    tick();
    check("man_r4c3", 64'(out_data), 64'h10000043);
    check("man_r4row", 64'(out_row), 64'd4);
    row = 5'b00001; col = 2'd0; abort = 1;
    tick();
    check("idle_abort_data", 64'(out_data), 64'h10000000);
    abort = 0;

    // Single sweep with ready held high
    mode = 1; start = 1; out_ready = 1;
    tick();
    start = 0;
    for (int i = 0; i < N; i++) begin
      check("sweep_data",  64'(out_data),  64'(exp_seq(i)));
      check("sweep_last",  64'(out_last),  64'(i == N - 1));
      check("sweep_valid", 64'(out_valid), 64'd1);
      tick();
    end
    check("sweep_end_valid", 64'(out_valid), 64'd0);
    check("sweep_end_busy",  64'(busy),      64'd0);

    // Backpressure, with table corruption during some stalls
    start = 1;
    tick();
    start = 0; got = 0; cyc = 0; held = '0; held_valid = 0;
    while (got < N && cyc < 200) begin
      out_ready = pat[cyc % 6] != 0;
      if (held_valid) check("bp_hold", 64'(out_data), 64'(held));
      if (!out_ready && (cyc == 4 || cyc == 10)) scramble_tbl();
      else init_tbl();
      if (out_valid && out_ready) begin
        check("bp_data", 64'(out_data), 64'(exp_seq(got)));
        got++;
        held_valid = 0;
      end else begin
        held = out_data;
        held_valid = 1;
      end
      cyc++;
      tick();
    end
    init_tbl();
    check("bp_count", 64'(got), 64'(N));
    check("bp_end_valid", 64'(out_valid), 64'd0);

    // Continuous wrap, ignored start, then abort
    continuous = 1; out_ready = 1; start = 1;
    tick();
    for (int i = 0; i < 23; i++) begin
      start = (i >= 5 && i <= 7);
      check("cont_data", 64'(out_data), 64'(exp_seq(i % N)));
      check("cont_last", 64'(out_last), 64'((i % N) == N - 1));
      if (i == N) check("cont_wrap", 64'(out_data), 64'h10000000);
      tick();
    end
    start = 0; abort = 1;
    tick();
    abort = 0; continuous = 0;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_busy",  64'(busy),      64'd0);
    check("abort_last",  64'(out_last),  64'd0);

    // Reset on a stalled beat (2,1)
    start = 1; out_ready = 1;
    tick();
    start = 0;
    repeat (9) tick();
    check("pre_rst_data", 64'(out_data), 64'h10000021);
    out_ready = 0;
    tick();
    check("stall_21", 64'(out_data), 64'h10000021);
    rst = 1;
    tick();
    rst = 0;
    check("mid_rst_data",  64'(out_data),  64'hDEADBEEF);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy",  64'(busy),      64'd0);
    out_ready = 1; start = 1;
    tick();
    start = 0;
    check("resume_data",  64'(out_data),  64'h10000000);
    check("resume_valid", 64'(out_valid), 64'd1);
    tick();
    check("resume_next", 64'(out_data), 64'h10000001);
    abort = 1;
    tick();
    abort = 0;
    check("final_valid", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
